fsu_bsg: RTL and testbench

- Upstream stage of the FSU scaled adder: turns IDIM binary operands into IDIM parallel unipolar unary bitstreams (iBit lanes of the adder).
- One shared, full-period RNG. Each lane compares its buffered operand against a lane-permuted copy of the RNG value.
- Each accepted operand set yields exactly LEN = 2^BWID output cycles.
- The ones-count on lane i over a run equals the operand exactly.

---
 rtl/fsu_bsg_pkg.sv | 24 ++
 rtl/fsu_rng.sv | 34 +++
 rtl/fsu_bsg.sv | 105 ++++++++++
 tb/tb_fsu_bsg.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsu_bsg_pkg.sv
// rtl/fsu_bsg_pkg.sv - shared types, LFSR tap table and counter sizing for the FSU bitstream generator
package fsu_bsg_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    // Fibonacci taps (bit t-1 set for tap t); every entry is a primitive polynomial
    function automatic logic [9:0] lfsr_taps(input int bwid);
        case (bwid)
            4:       return 10'b00_0000_1100;
            5:       return 10'b00_0001_0100;
            6:       return 10'b00_0011_0000;
            7:       return 10'b00_0110_0000;
            8:       return 10'b00_1011_1000;
            9:       return 10'b01_0001_0000;
            10:      return 10'b10_0100_0000;
            default: return 10'b00_0000_0000;
        endcase
    endfunction

    function automatic int cnt_width(input int bwid);
        return $clog2(2 ** bwid) + 1;
    endfunction

endpackage

// File: rtl/fsu_rng.sv
// rtl/fsu_rng.sv - zero-inserted (de Bruijn) Fibonacci LFSR covering all 2^BWID states
module fsu_rng
    import fsu_bsg_pkg::*;
#(
    parameter int BWID = 8,
    parameter int SEED = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            en,
    input  logic [BWID-1:0] seed,
    output logic [BWID-1:0] rng
);

    localparam logic [9:0]      TAPS_ALL = lfsr_taps(BWID);
    localparam logic [BWID-1:0] TAPS     = TAPS_ALL[BWID-1:0];

    logic fb;

    // Flipping feedback when the low bits are all zero splices 0 in between 10..0 and 0..01
    assign fb = (^(rng & TAPS)) ^ (rng[BWID-2:0] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rng <= BWID'(SEED);
        end else if (load) begin
            rng <= seed;
        end else if (en) begin
            rng <= {rng[BWID-2:0], fb};
        end
    end

endmodule

// File: rtl/fsu_bsg.sv
// rtl/fsu_bsg.sv - FSU unary bitstream generator; define FSU_BSG_B2B_EN for back-to-back loads
module fsu_bsg
    import fsu_bsg_pkg::*;
#(
    parameter int IDIM = 3,
    parameter int BWID = 8,
    parameter int LEN  = 2 ** BWID,
    parameter int SEED = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iValid,
    output logic            iReady,
    input  logic [BWID-1:0] iData [IDIM],
    output logic            oBit  [IDIM],
    output logic            oValid,
    output logic            oLast
);

    localparam int CW = cnt_width(BWID);

    state_t          state;
    logic [BWID-1:0] buf_q    [IDIM];
    logic [BWID-1:0] rng_lane [IDIM];
    logic [CW-1:0]   cnt;
    logic [BWID-1:0] rng;
    logic            last_cyc;
    logic            accept;

    assign last_cyc = (cnt == CW'(LEN - 1));

`ifdef FSU_BSG_B2B_EN
    assign iReady = (state == IDLE) || ((state == RUN) && last_cyc);
`else
    assign iReady = (state == IDLE);
`endif

    assign accept = iValid && iReady;

    fsu_rng #(
        .BWID (BWID),
        .SEED (SEED)
    ) u_rng (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    (state == RUN),
        .seed  (BWID'(SEED)),
        .rng   (rng)
    );

    // Each lane sees the shared RNG rotated left by its index, still a full permutation
    for (genvar i = 0; i < IDIM; i++) begin : g_lane
        localparam int ROT = i % BWID;
        if (ROT == 0) begin : g_norot
            assign rng_lane[i] = rng;
        end else begin : g_rot
            assign rng_lane[i] = {rng[BWID-1-ROT:0], rng[BWID-1:BWID-ROT]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            oValid <= 1'b0;
            oLast  <= 1'b0;
            for (int i = 0; i < IDIM; i++) begin
                buf_q[i] <= '0;
                oBit[i]  <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    oValid <= 1'b0;
                    oLast  <= 1'b0;
                    for (int i = 0; i < IDIM; i++) begin
                        oBit[i] <= 1'b0;
                    end
                end
                RUN: begin
                    oValid <= 1'b1;
                    oLast  <= last_cyc;
                    cnt    <= cnt + CW'(1);
                    for (int i = 0; i < IDIM; i++) begin
                        oBit[i] <= (buf_q[i] > rng_lane[i]);
                    end
                    if (last_cyc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A load overrides the end-of-run return to IDLE so back-to-back streams stay contiguous
            if (accept) begin
                state <= RUN;
                cnt   <= '0;
                for (int i = 0; i < IDIM; i++) begin
                    buf_q[i] <= iData[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fsu_bsg.sv
// tb/tb_fsu_bsg.sv - directed self-checking bench for fsu_bsg (BWID=8/IDIM=3 and BWID=4/IDIM=5)
module tb_fsu_bsg;
    import fsu_bsg_pkg::*;

`ifdef FSU_BSG_B2B_EN
    localparam int EXP_GAP = 0;
    localparam int EXP_RDY = 1;
`else
    localparam int EXP_GAP = 1;
    localparam int EXP_RDY = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       iValid = 1'b0;
    logic       iReady;
    logic [7:0] iData [3];
    logic       oBit  [3];
    logic       oValid;
    logic       oLast;

    logic       v4 = 1'b0;
    logic       rdy4;
    logic [3:0] d4 [5];
    logic       b4 [5];
    logic       ov4;
    logic       ol4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsu_bsg dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .iValid (iValid),
        .iReady (iReady),
        .iData  (iData),
        .oBit   (oBit),
        .oValid (oValid),
        .oLast  (oLast)
    );

    fsu_bsg #(.IDIM(5), .BWID(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .iValid (v4),
        .iReady (rdy4),
        .iData  (d4),
        .oBit   (b4),
        .oValid (ov4),
        .oLast  (ol4)
    );

    task automatic chk(input string tag, input bit pass, input longint obs, input longint exp);
        checks++;
        if (!pass) begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int cur_c [3];
    int cur_len = 0;
    int cur_rdy = 0;
    int cur_gap = 0;
    int gap_cnt = 0;
    int q_c0[$], q_c1[$], q_c2[$], q_len[$], q_gap[$], q_rdy[$];

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cur_c[i] = 0;
            cur_len = 0;
            cur_rdy = 0;
            cur_gap = 0;
            gap_cnt = 0;
        end else if (oValid) begin
            if (cur_len == 0) cur_gap = gap_cnt;
            for (int i = 0; i < 3; i++) cur_c[i] += int'(oBit[i]);
            cur_len++;
            if (iReady && !oLast) cur_rdy++;
            if (oLast) begin
                q_c0.push_back(cur_c[0]);
                q_c1.push_back(cur_c[1]);
                q_c2.push_back(cur_c[2]);
                q_len.push_back(cur_len);
                q_gap.push_back(cur_gap);
                q_rdy.push_back(cur_rdy);
                for (int i = 0; i < 3; i++) cur_c[i] = 0;
                cur_len = 0;
                cur_rdy = 0;
                gap_cnt = 0;
            end
        end else begin
            gap_cnt++;
        end
    end

    task automatic offer(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int ok;
        ok = 0;
        iData[0] = a;
        iData[1] = b;
        iData[2] = c;
        iValid = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (iReady) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", ok === 1, ok, 1);
        @(posedge clk);
        @(negedge clk);
        iValid = 1'b0;
        iData[0] = 8'hA5;
        iData[1] = 8'hA5;
        iData[2] = 8'hA5;
    endtask

    task automatic wait_streams(input int n);
        for (int k = 0; k < 3000; k++) begin
            if (q_len.size() >= n) break;
            @(negedge clk);
        end
        chk("streams_done", q_len.size() === n, q_len.size(), n);
    endtask

    task automatic wait_len(input int n);
        for (int k = 0; k < 400; k++) begin
            if (cur_len >= n) break;
            @(negedge clk);
        end
        chk("reach_len", cur_len === n, cur_len, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] first_rng;
        logic [7:0] v;
        bit         seen [256];
        int         distinct;
        int         s4 [5];
        int         n4;
        int         ok4;

        for (int i = 0; i < 3; i++) iData[i] = 8'h00;
        for (int i = 0; i < 5; i++) d4[i] = 4'h0;

        #1;
        chk("rst_ovalid", oValid === 1'b0, oValid, 0);
        chk("rst_olast", oLast === 1'b0, oLast, 0);
        chk("rst_obit", {oBit[0], oBit[1], oBit[2]} === 3'b000, {oBit[0], oBit[1], oBit[2]}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_iready", iReady === 1'b1, iReady, 1);
        @(negedge clk);

        offer(8'd0, 8'd128, 8'd255);
        first_rng = dut8.u_rng.rng;
        chk("rng_seed", first_rng === 8'd1, first_rng, 1);
        distinct = 0;
        for (int k = 0; k < 256; k++) begin
            v = dut8.u_rng.rng;
            if (!seen[v]) distinct++;
            seen[v] = 1'b1;
            @(negedge clk);
        end
        chk("rng_distinct", distinct === 256, distinct, 256);
        wait_streams(1);
        if (q_len.size() >= 1) begin
            chk("s1_len", q_len[0] === 256, q_len[0], 256);
            chk("s1_c0", q_c0[0] === 0, q_c0[0], 0);
            chk("s1_c1", q_c1[0] === 128, q_c1[0], 128);
            chk("s1_c2", q_c2[0] === 255, q_c2[0], 255);
            chk("s1_rdy", q_rdy[0] === EXP_RDY, q_rdy[0], EXP_RDY);
        end

        @(negedge clk);
        offer(8'd10, 8'd20, 8'd30);
        wait_len(10);
        offer(8'd7, 8'd7, 8'd7);
        wait_streams(3);
        if (q_len.size() >= 3) begin
            chk("s2_len", q_len[1] === 256, q_len[1], 256);
            chk("s2_c0", q_c0[1] === 10, q_c0[1], 10);
            chk("s2_c1", q_c1[1] === 20, q_c1[1], 20);
            chk("s2_c2", q_c2[1] === 30, q_c2[1], 30);
            chk("s3_len", q_len[2] === 256, q_len[2], 256);
            chk("s3_c0", q_c0[2] === 7, q_c0[2], 7);
            chk("s3_c1", q_c1[2] === 7, q_c1[2], 7);
            chk("s3_c2", q_c2[2] === 7, q_c2[2], 7);
            chk("s3_gap", q_gap[2] === EXP_GAP, q_gap[2], EXP_GAP);
        end

        @(negedge clk);
        offer(8'd255, 8'd255, 8'd255);
        wait_len(100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ovalid", oValid === 1'b0, oValid, 0);
        chk("mid_rst_olast", oLast === 1'b0, oLast, 0);
        chk("mid_rst_obit", {oBit[0], oBit[1], oBit[2]} === 3'b000, {oBit[0], oBit[1], oBit[2]}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_iready", iReady === 1'b1, iReady, 1);
        chk("post_rst_state", dut8.state === IDLE, dut8.state, IDLE);
        @(negedge clk);
        offer(8'd200, 8'd1, 8'd50);
        wait_streams(4);
        if (q_len.size() >= 4) begin
            chk("s4_len", q_len[3] === 256, q_len[3], 256);
            chk("s4_c0", q_c0[3] === 200, q_c0[3], 200);
            chk("s4_c1", q_c1[3] === 1, q_c1[3], 1);
            chk("s4_c2", q_c2[3] === 50, q_c2[3], 50);
        end

        @(negedge clk);
        d4[0] = 4'd0;
        d4[1] = 4'd4;
        d4[2] = 4'd8;
        d4[3] = 4'd12;
        d4[4] = 4'd15;
        v4 = 1'b1;
        ok4 = 0;
        for (int k = 0; k < 50; k++) begin
            if (rdy4) begin
                ok4 = 1;
                break;
            end
            @(negedge clk);
        end
        chk("w4_accept", ok4 === 1, ok4, 1);
        @(posedge clk);
        @(negedge clk);
        v4 = 1'b0;
        for (int i = 0; i < 5; i++) d4[i] = 4'hF;
        n4 = 0;
        for (int i = 0; i < 5; i++) s4[i] = 0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (ov4) begin
                n4++;
                for (int i = 0; i < 5; i++) s4[i] += int'(b4[i]);
            end
        end
        chk("w4_len", n4 === 16, n4, 16);
        chk("w4_c0", s4[0] === 0, s4[0], 0);
        chk("w4_c1", s4[1] === 4, s4[1], 4);
        chk("w4_c2", s4[2] === 8, s4[2], 8);
        chk("w4_c3", s4[3] === 12, s4[3], 12);
        chk("w4_c4", s4[4] === 15, s4[4], 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
